// File: rtl/pool_requant_chan.sv
// pool_requant_chan: accumulates per-channel 2x2 conv tiles, applies ReLU and
// 2x2 max-pooling, requantizes by an arithmetic right shift, and emits one
// saturated unsigned 8-bit pixel per output over a valid/ready handshake.
// Optional build macro POOL_ROUND_EN: round-half-up on the requantization
// shift instead of truncation.
module pool_requant_chan #(
  parameter int NUM_CHAN = 4,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [83:0] conv_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sat
);

  typedef enum logic [1:0] {ACC, POOL, OUT} state_t;

  localparam int              CNT_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHAN - 1);

  state_t                   state;
  logic [CNT_W-1:0]         chan_cnt;
  logic signed [ACC_W-1:0]  acc  [4];
  logic signed [ACC_W-1:0]  beat [4];
  logic [ACC_W-1:0]         relu [4];
  logic [ACC_W-1:0]         m;
  logic [ACC_W:0]           q;
  logic                     sat;

  // Combinational ready: low during reset and outside the accumulate phase.
  assign in_ready = rst & (state == ACC);

  // Sign-extend each 21-bit tile sum to the accumulator width.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      beat[i] = ACC_W'($signed(conv_in[i*21 +: 21]));
    end
  end

  // ReLU followed by max over the four pooled positions; lowest index wins ties.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    m = '0;
    for (int i = 0; i < 4; i++) begin
      relu[i] = acc[i][ACC_W-1] ? '0 : acc[i];
      if (relu[i] > m) m = relu[i];
    end
  end

  // Requantization shift; m is non-negative so a logical shift is equivalent.
`ifdef POOL_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
  assign q = ({1'b0, m} + HALF) >> SHIFT;
`else
  assign q = {1'b0, m} >> SHIFT;
`endif

  assign sat = |q[ACC_W:8];

  // Control FSM with accumulators and registered output pixel.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: accumulators are cleared on reset because a partial channel sum
    // must never survive into the next pixel after a mid-operation reset.
    if (!rst) begin
      state     <= ACC;
      chan_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        ACC: begin
          if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
              acc[i] <= (chan_cnt == '0) ? beat[i] : acc[i] + beat[i];
            end
            if (chan_cnt == LAST) begin
              chan_cnt <= '0;
              state    <= POOL;
            end else begin
              chan_cnt <= chan_cnt + 1'b1;
            end
          end
        end
        POOL: begin
          out_data  <= sat ? 8'hFF : q[7:0];
          out_sat   <= sat;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_requant_chan.sv
// Directed testbench for pool_requant_chan (NUM_CHAN=4, ACC_W=24, SHIFT=4).
module tb_pool_requant_chan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [83:0] conv_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_sat;

  int total = 0;
  int bad   = 0;

`ifdef POOL_ROUND_EN
  localparam int EXP_BASIC = 19;   // (300 + 8) >> 4
`else
  localparam int EXP_BASIC = 18;   // 300 >> 4
`endif

  pool_requant_chan #(.NUM_CHAN(4), .ACC_W(24), .SHIFT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .conv_in   (conv_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [83:0] pack(input int a, input int b, input int c, input int d);
    return {21'(d), 21'(c), 21'(b), 21'(a)};
  endfunction

  // Present one tile and hold it until accepted; returns just after the accept edge.
  task automatic send_beat(input int a, input int b, input int c, input int d);
    bit ok = 1'b0;
    @(negedge clk);
    conv_in  = pack(a, b, c, d);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  // Wait for a pixel, check it, complete the handshake and check the recovery.
  task automatic take_out(input string tag, input int exp_data, input bit exp_sat);
    wait_out(tag);
    check({tag, "_data"}, {24'd0, out_data}, exp_data);
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic back-to-back, with latency check
    for (int i = 0; i < 4; i++) send_beat(25, 50, 75, 10);
    @(negedge clk);
    check("lat_pool_not_valid", {31'd0, out_valid}, 32'd0);
    check("lat_pool_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    take_out("basic", EXP_BASIC, 1'b0);

    // All-negative tiles: ReLU clamps everything to zero
    for (int i = 0; i < 4; i++) send_beat(-500, -500, -500, -500);
    take_out("neg", 0, 1'b0);

    // Saturation: acc[3]=80000, q=5000
    for (int i = 0; i < 4; i++) send_beat(0, 0, 0, 20000);
    take_out("sat", 255, 1'b1);

    // Backpressure: hold out_ready low for 5 cycles
    for (int i = 0; i < 4; i++) send_beat(25, 50, 75, 10);
    wait_out("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {24'd0, out_data}, EXP_BASIC);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    take_out("bp", EXP_BASIC, 1'b0);

    // Gapped input: 3 idle cycles between beats
    for (int i = 0; i < 4; i++) begin
      send_beat(25, 50, 75, 10);
      if (i < 3) begin
        repeat (3) @(negedge clk);
        check("gap_no_output", {31'd0, out_valid}, 32'd0);
        check("gap_in_ready", {31'd0, in_ready}, 32'd1);
      end
    end
    take_out("gap", EXP_BASIC, 1'b0);

    // Reset mid-accumulation discards partial sums
    send_beat(1000, 1000, 1000, 1000);
    send_beat(1000, 1000, 1000, 1000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send_beat(16, 32, 48, 64);
    send_beat(16, 32, 48, 64);
    repeat (3) @(negedge clk);
    check("midrst_no_early_out", {31'd0, out_valid}, 32'd0);
    send_beat(16, 32, 48, 64);
    send_beat(16, 32, 48, 64);
    take_out("midrst", 16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
